// File: rtl/mealy_fsm.sv
// -----------------------------------------------------------------------------
// mealy_fsm
//
// Purpose:
//    Serial "110" sequence detector, Mealy style, with overlap. The registered
//    state remembers how many consecutive 1s have been sampled (none, one, or
//    two-or-more). The detect flag is formed combinationally from that state
//    and the live input bit, so it rises in the same cycle as the final 0.
//
// Ports:
//    clk     in   system clock; the state advances on the rising edge
//    nRESET  in   asynchronous reset, ACTIVE-HIGH despite the legacy name
//                 (1 = hold in idle, 0 = run)
//    in      in   serial data bit, sampled on each rising clk
//    out     out  detect flag: high while armed (two 1s seen) and in == 0
// -----------------------------------------------------------------------------
module mealy_fsm (
   input  logic clk,
   input  logic nRESET,
   input  logic in,
   output logic out
);

   typedef enum logic [1:0] {
      S0    = 2'b00,  // idle, or last bit was 0
      S1    = 2'b01,  // last bit was 1
      S2    = 2'b10,  // last two bits were 1,1 (armed)
      S_ILL = 2'b11   // unused encoding, recovers to S0
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   in_one;
   logic   in_zero;
   logic   detect;

   // Case equality keeps X/Z on the input from advancing the FSM or
   // raising the flag: only a clean 1 counts as a 1, only a clean 0 can
   // complete a match.
   assign in_one  = (in === 1'b1);
   assign in_zero = (in === 1'b0);

   always_comb begin
      state_d = S0;
      detect  = 1'b0;
      case (state_q)
         S0: state_d = in_one ? S1 : S0;
         S1: state_d = in_one ? S2 : S0;
         S2: begin
            // A run of 1s keeps the detector armed; the first 0 fires and
            // returns to idle (that 0 cannot begin a new match).
            state_d = in_one ? S2 : S0;
            detect  = in_zero;
         end
         default: state_d = S0;
      endcase
   end

   // Reset forces S0 asynchronously, which already clears detect; the extra
   // gate keeps out low in the same delta as reset assertion.
   assign out = detect & ~nRESET;

   always_ff @(posedge clk or posedge nRESET) begin
      if (nRESET) begin
         state_q <= S0;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: tb/tb_mealy_fsm.sv
module tb_mealy_fsm;

   logic clk;
   logic nRESET;
   logic in;
   logic out;

   int checks;
   int errors;

   // Reference: the list of bits sampled since the last reset release.
   // A detection is "the two most recent samples are both 1 and the live bit
   // is 0", with nothing counted while reset is asserted.
   bit hist[$];

   mealy_fsm dut (
      .clk    (clk),
      .nRESET (nRESET),
      .in     (in),
      .out    (out)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   function automatic logic model_out();
      logic r;
      r = 1'b0;
      if (!nRESET && hist.size() >= 2)
         r = hist[hist.size()-1] && hist[hist.size()-2] && (in === 1'b0);
      return r;
   endfunction

   task automatic check(input string tag);
      logic exp;
      exp = model_out();
      checks++;
      assert (out === exp) else begin
         errors++;
         $error("FAIL %s: out=%b expected=%b", tag, out, exp);
      end
   endtask

   // Let the rising edge sample the current input into the model.
   task automatic tick();
      @(posedge clk);
      if (nRESET) hist.delete();
      else begin
         hist.push_back(in === 1'b1);
         if (hist.size() > 8) void'(hist.pop_front());
      end
      #1;
   endtask

   // Drive one bit on the falling edge, check mid-low-phase, then clock it in.
   task automatic step(input logic b, input string tag);
      @(negedge clk);
      in = b;
      #10;
      check(tag);
      tick();
   endtask

   task automatic run_seq(input logic [15:0] bits, input int n, input string tag);
      logic [15:0] v;
      v = bits;
      for (int i = n - 1; i >= 0; i--) step(v[i], $sformatf("%s[%0d]", tag, n - 1 - i));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      in     = 1'b0;
      nRESET = 1'b1;
      #1;
      check("reset_initial");

      // Reset held while 1,1,0 is presented: never armed, never fires.
      run_seq(16'b110, 3, "reset_held");

      // Release between edges; takes effect from the next rising edge.
      @(negedge clk);
      nRESET = 1'b0;
      hist.delete();

      run_seq(16'b0010000, 7, "single_one");
      run_seq(16'b1111100, 7, "long_run");
      run_seq(16'b110110, 6, "back_to_back");

      // Async reset mid-pattern: arm with 1,1, show the live detect, then
      // pulse reset between edges; flag must drop immediately and stay low.
      run_seq(16'b11, 2, "arm");
      @(negedge clk);
      in = 1'b0;
      #5;  check("pre_reset_detect");
      nRESET = 1'b1;
      #1;  check("reset_drop_same_delta");
      #5;  nRESET = 1'b0;
      hist.delete();
      #1;  check("after_reset_pulse");
      tick();
      step(1'b0, "post_reset_zero");

      // Combinational path: armed, toggle in 1 -> 0 -> 1 inside one low phase.
      run_seq(16'b11, 2, "arm2");
      @(negedge clk);
      in = 1'b1; #5; check("mealy_in1_a");
      in = 1'b0; #5; check("mealy_in0");
      in = 1'b1; #5; check("mealy_in1_b");
      tick();
      step(1'b0, "mealy_still_armed");
      step(1'b0, "mealy_after_fire");

      // Random stream with occasional asynchronous reset pulses.
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         in = 1'($urandom_range(0, 99) < 60);
         #10;
         check("rand");
         if ($urandom_range(0, 39) == 0) begin
            nRESET = 1'b1;
            #1; check("rand_reset");
            #4; nRESET = 1'b0;
            hist.delete();
            #1; check("rand_after_reset");
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
